e203_exu_oitf: RTL and testbench

- Outstanding Instruction Track FIFO. It is the responder side of the dispatch-to-OITF interface.
- Allocates one entry per long-pipe instruction dispatched (LSU/AGU, later FPU) and returns the entry index as the instruction tag.
- Releases the oldest entry when the long pipe writes back.
- Compares the dispatching instruction's source and destination registers against all live entries to flag RAW/WAW hazards. Provides empty/ready status to dispatch and to WFI halt logic.

---
 rtl/e203_exu_oitf_pkg.sv | 29 ++
 rtl/e203_exu_oitf_if.sv | 39 +++
 rtl/e203_exu_oitf_entry.sv | 35 +++
 rtl/e203_exu_oitf.sv | 83 ++++++++
 tb/tb_e203_exu_oitf.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/e203_exu_oitf_pkg.sv
// e203_exu_oitf_pkg: shared widths, entry/operand types and pointer advance for the OITF.
package e203_exu_oitf_pkg;
   localparam int OITF_DEPTH  = 2;
   localparam int ITAG_WIDTH  = (OITF_DEPTH > 1) ? $clog2(OITF_DEPTH) : 1;
   localparam int RFIDX_WIDTH = 5;
   localparam int PC_SIZE     = 32;

   typedef logic [ITAG_WIDTH-1:0]  itag_t;
   typedef logic [RFIDX_WIDTH-1:0] rfidx_t;
   typedef logic [PC_SIZE-1:0]     pc_t;

   typedef struct packed {
      rfidx_t rdidx;
      logic   rdwen;
      logic   rdfpu;
      pc_t    pc;
   } oitf_ent_t;

   typedef struct packed {
      logic   en;
      logic   fpu;
      rfidx_t idx;
   } rf_op_t;

   // Returns {wrap_flag, ptr} after one step; the flag toggles on wrap.
   function automatic logic [ITAG_WIDTH:0] ptr_adv(input logic flg, input itag_t ptr);
      return (ptr == itag_t'(OITF_DEPTH - 1)) ? {~flg, itag_t'(0)} : {flg, ptr + itag_t'(1)};
   endfunction
endpackage

// File: rtl/e203_exu_oitf_if.sv
// e203_exu_oitf_if: dispatch/retire to OITF signal bundle; master drives requests, slave is the OITF.
interface e203_exu_oitf_if;
   import e203_exu_oitf_pkg::*;
   logic   dis_ready;
   logic   dis_ena;
   itag_t  dis_ptr;
   logic   ret_ena;
   itag_t  ret_ptr;
   rfidx_t ret_rdidx;
   logic   ret_rdwen;
   logic   ret_rdfpu;
   pc_t    ret_pc;
   logic   disp_i_rs1en, disp_i_rs2en, disp_i_rs3en, disp_i_rdwen;
   logic   disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu, disp_i_rdfpu;
   rfidx_t disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx, disp_i_rdidx;
   pc_t    disp_i_pc;
   logic   oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3, oitfrd_match_disprd;
   logic   oitf_empty;

   modport master (
      output dis_ena, ret_ena,
      output disp_i_rs1en, disp_i_rs2en, disp_i_rs3en, disp_i_rdwen,
      output disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu, disp_i_rdfpu,
      output disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx, disp_i_rdidx, disp_i_pc,
      input  dis_ready, dis_ptr, ret_ptr, ret_rdidx, ret_rdwen, ret_rdfpu, ret_pc,
      input  oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3, oitfrd_match_disprd,
      input  oitf_empty
   );

   modport slave (
      input  dis_ena, ret_ena,
      input  disp_i_rs1en, disp_i_rs2en, disp_i_rs3en, disp_i_rdwen,
      input  disp_i_rs1fpu, disp_i_rs2fpu, disp_i_rs3fpu, disp_i_rdfpu,
      input  disp_i_rs1idx, disp_i_rs2idx, disp_i_rs3idx, disp_i_rdidx, disp_i_pc,
      output dis_ready, dis_ptr, ret_ptr, ret_rdidx, ret_rdwen, ret_rdfpu, ret_pc,
      output oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprs3, oitfrd_match_disprd,
      output oitf_empty
   );
endinterface

// File: rtl/e203_exu_oitf_entry.sv
// e203_exu_oitf_entry: one OITF slot -- valid bit, rd/pc payload and its four hazard comparators.
module e203_exu_oitf_entry
   import e203_exu_oitf_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            set_i,
   input  logic            clr_i,
   input  oitf_ent_t       ent_i,
   input  rf_op_t    [3:0] ops_i,
   output oitf_ent_t       ent_o,
   output logic      [3:0] match_o
);
   logic      vld_q, vld_d;
   oitf_ent_t ent_q;

   assign vld_d = set_i | (vld_q & ~clr_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= 1'b0;
      else        vld_q <= vld_d;
   end

   // Payload is only observed while valid, so it carries no reset.
   always_ff @(posedge clk) begin
      if (set_i) ent_q <= ent_i;
   end

   for (genvar k = 0; k < 4; k++) begin : g_cmp
      assign match_o[k] = vld_q & ent_q.rdwen & ops_i[k].en
                        & (ent_q.rdfpu == ops_i[k].fpu) & (ent_q.rdidx == ops_i[k].idx);
   end

   assign ent_o = ent_q;
endmodule

// File: rtl/e203_exu_oitf.sv
// e203_exu_oitf: outstanding instruction track FIFO -- allocates tags for long-pipe ops,
// retires in order, and flags RAW/WAW hazards of the dispatching instruction.
module e203_exu_oitf
   import e203_exu_oitf_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   e203_exu_oitf_if.slave oitf
);
   itag_t          alc_ptr_q, alc_ptr_d, ret_ptr_q, ret_ptr_d;
   logic           alc_flg_q, alc_flg_d, ret_flg_q, ret_flg_d;
   logic           ptr_eq, empty, full, alc_go, ret_go;
   oitf_ent_t      ent_new, ent_ret;
   oitf_ent_t      ent [OITF_DEPTH];
   logic     [3:0] ent_match [OITF_DEPTH];
   logic     [3:0] match;
   rf_op_t   [3:0] ops;

   assign ptr_eq = alc_ptr_q == ret_ptr_q;
   assign empty  = ptr_eq & (alc_flg_q == ret_flg_q);
   assign full   = ptr_eq & (alc_flg_q != ret_flg_q);
   assign alc_go = oitf.dis_ena & ~full;
   assign ret_go = oitf.ret_ena & ~empty;

   always_comb begin
      {alc_flg_d, alc_ptr_d} = alc_go ? ptr_adv(alc_flg_q, alc_ptr_q) : {alc_flg_q, alc_ptr_q};
      {ret_flg_d, ret_ptr_d} = ret_go ? ptr_adv(ret_flg_q, ret_ptr_q) : {ret_flg_q, ret_ptr_q};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alc_ptr_q <= '0;
         alc_flg_q <= 1'b0;
         ret_ptr_q <= '0;
         ret_flg_q <= 1'b0;
      end else begin
         alc_ptr_q <= alc_ptr_d;
         alc_flg_q <= alc_flg_d;
         ret_ptr_q <= ret_ptr_d;
         ret_flg_q <= ret_flg_d;
      end
   end

   assign ent_new = '{rdidx: oitf.disp_i_rdidx, rdwen: oitf.disp_i_rdwen,
                      rdfpu: oitf.disp_i_rdfpu, pc: oitf.disp_i_pc};
   // Slot order: [0]=rs1, [1]=rs2, [2]=rs3, [3]=rd.
   assign ops = {oitf.disp_i_rdwen, oitf.disp_i_rdfpu, oitf.disp_i_rdidx,
                 oitf.disp_i_rs3en, oitf.disp_i_rs3fpu, oitf.disp_i_rs3idx,
                 oitf.disp_i_rs2en, oitf.disp_i_rs2fpu, oitf.disp_i_rs2idx,
                 oitf.disp_i_rs1en, oitf.disp_i_rs1fpu, oitf.disp_i_rs1idx};

   for (genvar i = 0; i < OITF_DEPTH; i++) begin : g_ent
      e203_exu_oitf_entry u_ent (
         .clk     (clk),
         .rst_n   (rst_n),
         .set_i   (alc_go && alc_ptr_q == itag_t'(i)),
         .clr_i   (ret_go && ret_ptr_q == itag_t'(i)),
         .ent_i   (ent_new),
         .ops_i   (ops),
         .ent_o   (ent[i]),
         .match_o (ent_match[i])
      );
   end

   always_comb begin
      match = '0;
      for (int k = 0; k < OITF_DEPTH; k++) match = match | ent_match[k];
   end

   assign ent_ret                   = ent[ret_ptr_q];
   assign oitf.dis_ready            = ~full;
   assign oitf.dis_ptr              = alc_ptr_q;
   assign oitf.ret_ptr              = ret_ptr_q;
   assign oitf.ret_rdidx            = ent_ret.rdidx;
   assign oitf.ret_rdwen            = ent_ret.rdwen;
   assign oitf.ret_rdfpu            = ent_ret.rdfpu;
   assign oitf.ret_pc               = ent_ret.pc;
   assign oitf.oitf_empty           = empty;
   assign oitf.oitfrd_match_disprs1 = match[0];
   assign oitf.oitfrd_match_disprs2 = match[1];
   assign oitf.oitfrd_match_disprs3 = match[2];
   assign oitf.oitfrd_match_disprd  = match[3];
endmodule

// File: tb/tb_e203_exu_oitf.sv
// tb_e203_exu_oitf: queue-based occupancy model checked every cycle, plus directed literal checks.
module tb_e203_exu_oitf;
   import e203_exu_oitf_pkg::*;

   logic clk = 1'b0, rst_n = 1'b1, mon_en = 1'b0;
   int   checks = 0, failures = 0;

   e203_exu_oitf_if bus();
   e203_exu_oitf dut (.clk(clk), .rst_n(rst_n), .oitf(bus));

   always #5 clk = ~clk;

   typedef struct {
      logic [RFIDX_WIDTH-1:0] rdidx;
      logic                   rdwen;
      logic                   rdfpu;
      logic [PC_SIZE-1:0]     pc;
   } rec_t;

   rec_t q[$];
   int   alc_cnt = 0, ret_cnt = 0;
   bit   do_alc, do_ret;

   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   function automatic logic hit(input logic en, input logic fpu, input logic [RFIDX_WIDTH-1:0] idx);
      logic h = 1'b0;
      foreach (q[j]) h |= q[j].rdwen & en & (q[j].rdfpu == fpu) & (q[j].rdidx == idx);
      return h;
   endfunction

   // In-order FIFO of live instructions; pointer values follow from total alloc/retire counts.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         alc_cnt = 0;
         ret_cnt = 0;
      end else begin
         do_alc = bus.dis_ena && q.size() < OITF_DEPTH;
         do_ret = bus.ret_ena && q.size() > 0;
         if (do_ret) begin
            void'(q.pop_front());
            ret_cnt++;
         end
         if (do_alc) begin
            q.push_back('{bus.disp_i_rdidx, bus.disp_i_rdwen, bus.disp_i_rdfpu, bus.disp_i_pc});
            alc_cnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("dis_ready", 64'(bus.dis_ready), 64'(q.size() < OITF_DEPTH));
         chk("dis_ptr", 64'(bus.dis_ptr), 64'(alc_cnt % OITF_DEPTH));
         chk("ret_ptr", 64'(bus.ret_ptr), 64'(ret_cnt % OITF_DEPTH));
         chk("oitf_empty", 64'(bus.oitf_empty), 64'(q.size() == 0));
         chk("m_rs1", 64'(bus.oitfrd_match_disprs1), 64'(hit(bus.disp_i_rs1en, bus.disp_i_rs1fpu, bus.disp_i_rs1idx)));
         chk("m_rs2", 64'(bus.oitfrd_match_disprs2), 64'(hit(bus.disp_i_rs2en, bus.disp_i_rs2fpu, bus.disp_i_rs2idx)));
         chk("m_rs3", 64'(bus.oitfrd_match_disprs3), 64'(hit(bus.disp_i_rs3en, bus.disp_i_rs3fpu, bus.disp_i_rs3idx)));
         chk("m_rd", 64'(bus.oitfrd_match_disprd), 64'(hit(bus.disp_i_rdwen, bus.disp_i_rdfpu, bus.disp_i_rdidx)));
         if (q.size() > 0) begin
            chk("ret_rdidx", 64'(bus.ret_rdidx), 64'(q[0].rdidx));
            chk("ret_rdwen", 64'(bus.ret_rdwen), 64'(q[0].rdwen));
            chk("ret_rdfpu", 64'(bus.ret_rdfpu), 64'(q[0].rdfpu));
            chk("ret_pc", 64'(bus.ret_pc), 64'(q[0].pc));
         end
      end
   end

   task automatic idle();
      bus.dis_ena = 0; bus.ret_ena = 0;
      bus.disp_i_rs1en = 0; bus.disp_i_rs2en = 0; bus.disp_i_rs3en = 0; bus.disp_i_rdwen = 0;
      bus.disp_i_rs1fpu = 0; bus.disp_i_rs2fpu = 0; bus.disp_i_rs3fpu = 0; bus.disp_i_rdfpu = 0;
      bus.disp_i_rs1idx = '0; bus.disp_i_rs2idx = '0; bus.disp_i_rs3idx = '0; bus.disp_i_rdidx = '0;
      bus.disp_i_pc = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      #2 rst_n = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      mon_en = 1;
      @(negedge clk);
      chk("rst_empty", 64'(bus.oitf_empty), 64'd1);
      chk("rst_ready", 64'(bus.dis_ready), 64'd1);
      chk("rst_dis_ptr", 64'(bus.dis_ptr), 64'd0);
      chk("rst_ret_ptr", 64'(bus.ret_ptr), 64'd0);
      chk("rst_matches", 64'({bus.oitfrd_match_disprs1, bus.oitfrd_match_disprs2,
                              bus.oitfrd_match_disprs3, bus.oitfrd_match_disprd}), 64'd0);
      // Fill: x5 then x6.
      bus.disp_i_rdidx = 5; bus.disp_i_rdwen = 1; bus.disp_i_pc = 32'h100; bus.dis_ena = 1;
      step();
      bus.disp_i_rdidx = 6; bus.disp_i_pc = 32'h104;
      @(negedge clk);
      chk("a1_dis_ptr", 64'(bus.dis_ptr), 64'd1);
      chk("a1_empty", 64'(bus.oitf_empty), 64'd0);
      chk("a1_ret_rdidx", 64'(bus.ret_rdidx), 64'd5);
      chk("a1_m_rd_x6", 64'(bus.oitfrd_match_disprd), 64'd0);
      step();
      bus.dis_ena = 0; bus.disp_i_rs1idx = 5; bus.disp_i_rs1en = 1; bus.disp_i_rdidx = 5;
      @(negedge clk);
      chk("full_dis_ptr", 64'(bus.dis_ptr), 64'd0);
      chk("full_ready", 64'(bus.dis_ready), 64'd0);
      chk("x5_m_rs1", 64'(bus.oitfrd_match_disprs1), 64'd1);
      chk("x5_m_rd", 64'(bus.oitfrd_match_disprd), 64'd1);
      bus.disp_i_rs1en = 0;
      #1 chk("x5_rs1en0", 64'(bus.oitfrd_match_disprs1), 64'd0);
      bus.disp_i_rs1en = 1; bus.disp_i_rs1fpu = 1;
      #1 chk("x5_rs1fpu", 64'(bus.oitfrd_match_disprs1), 64'd0);
      bus.disp_i_rs1fpu = 0;
      #1 chk("x5_rs1_again", 64'(bus.oitfrd_match_disprs1), 64'd1);
      // Full: retire proceeds, allocation blocked.
      bus.dis_ena = 1; bus.ret_ena = 1; bus.disp_i_rdidx = 7; bus.disp_i_pc = 32'h108;
      step();
      bus.dis_ena = 0; bus.ret_ena = 0;
      @(negedge clk);
      chk("fr_ret_ptr", 64'(bus.ret_ptr), 64'd1);
      chk("fr_ready", 64'(bus.dis_ready), 64'd1);
      chk("fr_dis_ptr", 64'(bus.dis_ptr), 64'd0);
      chk("fr_x5_gone", 64'(bus.oitfrd_match_disprs1), 64'd0);
      chk("fr_ret_rdidx", 64'(bus.ret_rdidx), 64'd6);
      // One live: both happen, occupancy stays 1.
      bus.dis_ena = 1; bus.ret_ena = 1;
      step();
      bus.dis_ena = 0; bus.ret_ena = 0;
      @(negedge clk);
      chk("one_ret_ptr", 64'(bus.ret_ptr), 64'd0);
      chk("one_dis_ptr", 64'(bus.dis_ptr), 64'd1);
      chk("one_empty", 64'(bus.oitf_empty), 64'd0);
      chk("one_ret_rdidx", 64'(bus.ret_rdidx), 64'd7);
      chk("one_ret_pc", 64'(bus.ret_pc), 64'h108);
      bus.ret_ena = 1;
      step();
      bus.ret_ena = 0;
      @(negedge clk);
      chk("drain_empty", 64'(bus.oitf_empty), 64'd1);
      chk("drain_ret_ptr", 64'(bus.ret_ptr), 64'd1);
      // Empty: retire blocked, allocation proceeds.
      bus.dis_ena = 1; bus.ret_ena = 1; bus.disp_i_rdidx = 9; bus.disp_i_pc = 32'h10c;
      step();
      bus.dis_ena = 0; bus.ret_ena = 0;
      @(negedge clk);
      chk("er_empty", 64'(bus.oitf_empty), 64'd0);
      chk("er_ret_ptr", 64'(bus.ret_ptr), 64'd1);
      chk("er_dis_ptr", 64'(bus.dis_ptr), 64'd0);
      chk("er_ret_rdidx", 64'(bus.ret_rdidx), 64'd9);
      // Random traffic with a reset pulse in the middle.
      for (int i = 0; i < 20; i++) begin
         if (i == 10) rst_n = 0;
         if (i == 11) rst_n = 1;
         bus.dis_ena = $urandom_range(0, 3) != 0;
         bus.ret_ena = 1'($urandom_range(0, 1));
         bus.disp_i_rdidx = RFIDX_WIDTH'($urandom_range(0, 7));
         bus.disp_i_rdwen = 1'($urandom_range(0, 1));
         bus.disp_i_rdfpu = $urandom_range(0, 3) == 0;
         bus.disp_i_pc = $urandom;
         bus.disp_i_rs1idx = RFIDX_WIDTH'($urandom_range(0, 7));
         bus.disp_i_rs2idx = RFIDX_WIDTH'($urandom_range(0, 7));
         bus.disp_i_rs3idx = RFIDX_WIDTH'($urandom_range(0, 7));
         bus.disp_i_rs1en = 1'($urandom_range(0, 1));
         bus.disp_i_rs2en = 1'($urandom_range(0, 1));
         bus.disp_i_rs3en = 1'($urandom_range(0, 1));
         bus.disp_i_rs1fpu = $urandom_range(0, 3) == 0;
         bus.disp_i_rs2fpu = $urandom_range(0, 3) == 0;
         bus.disp_i_rs3fpu = $urandom_range(0, 3) == 0;
         step();
      end
      idle();
      bus.dis_ena = 1; bus.disp_i_rdwen = 1; bus.disp_i_rdidx = 3;
      step();
      idle();
      @(negedge clk);
      chk("pre_rst_empty", 64'(bus.oitf_empty), 64'd0);
      #1 rst_n = 0;
      #2 rst_n = 1;
      @(negedge clk);
      chk("end_empty", 64'(bus.oitf_empty), 64'd1);
      chk("end_ready", 64'(bus.dis_ready), 64'd1);
      chk("end_dis_ptr", 64'(bus.dis_ptr), 64'd0);
      chk("end_ret_ptr", 64'(bus.ret_ptr), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
